mod_updown_counter: RTL and testbench

//   Parametrised modulo-N up/down counter with prescaler, synchronous load,
//   one-shot/free-running mode, upper-half flag and terminal-count pulse.

---
 rtl/mod_updown_counter_if.sv | 38 +++
 rtl/mod_updown_counter.sv | 96 +++++++++
 tb/tb_mod_updown_counter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mod_updown_counter_if.sv
// rtl/mod_updown_counter_if.sv - control/status bundle for the modulo up/down counter
//
// Purpose: groups the counter's control strobes and status outputs so the
//   counter and its user connect through one port.
// Signals:
//   en        count enable (low freezes count and prescaler)
//   up_dn     1 = count up, 0 = count down
//   load      synchronous load strobe, wins over en
//   load_val  value to load (clamped to MODULUS-1 by the counter)
//   one_shot  1 = halt at terminal value, 0 = wrap
//   count     current count
//   upper     count >= MODULUS/2
//   tc        one-clock terminal-count pulse
//   done      sticky one-shot completion flag
// Modports: master drives controls / reads status; slave is the counter.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             one_shot;
  logic [WIDTH-1:0] count;
  logic             upper;
  logic             tc;
  logic             done;

  modport master (
    output en, up_dn, load, load_val, one_shot,
    input  count, upper, tc, done
  );

  modport slave (
    input  en, up_dn, load, load_val, one_shot,
    output count, upper, tc, done
  );
endinterface

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo-N up/down counter with prescaler, load and one-shot
//
// Purpose: timer/sequencer primitive. Counts 0..MODULUS-1 up or down, one
//   step every PRESCALE enabled clocks. At the terminal value it either wraps
//   (free-running) or halts and raises a sticky done flag (one-shot). Every
//   terminal step produces a registered one-clock tc pulse.
// Parameters:
//   WIDTH     count register width, bits
//   MODULUS   count range 0..MODULUS-1, legal 2..2**WIDTH
//   PRESCALE  enabled clocks per count step, legal >= 1
// Ports:
//   clk       clock, all state updates on posedge
//   rst       asynchronous reset, active-high
//   bus       mod_updown_counter_if.slave: en, up_dn, load, load_val,
//             one_shot in; count, upper, tc, done out
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mod_updown_counter_if.slave    bus
);

  // Prescaler needs at least one bit even when PRESCALE == 1 (then it stays 0).
  localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0]  HALF    = WIDTH'(MODULUS / 2);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [PS_W-1:0]  ps;
  logic             tc_q;
  logic             done_q;

  logic [WIDTH-1:0] load_clamped;
  logic             terminal;
  logic             step;

  always_comb begin
    load_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;
    // Direction is sampled at the step itself, so up_dn may change mid-prescale.
    terminal     = bus.up_dn ? (count_q == MAX_CNT) : (count_q == '0);
    step         = (ps == PS_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      count_q <= '0;
      ps      <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load) begin
        // Load restarts a full prescale period and never steps in the same cycle.
        count_q <= load_clamped;
        ps      <= '0;
        done_q  <= 1'b0;
        state   <= RUN;
      end else if (bus.en && state == RUN) begin
        if (step) begin
          ps <= '0;
          if (terminal) begin
            tc_q <= 1'b1;
            if (bus.one_shot) begin
              // count keeps its terminal value while halted
              state  <= HALT;
              done_q <= 1'b1;
            end else begin
              count_q <= bus.up_dn ? '0 : MAX_CNT;
            end
          end else begin
            count_q <= bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
          end
        end else begin
          ps <= ps + PS_W'(1);
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.upper = (count_q >= HALF);
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - directed self-checking bench for mod_updown_counter
module tb_mod_updown_counter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mod_updown_counter_if #(.WIDTH(4)) b0 ();
  mod_updown_counter_if #(.WIDTH(4)) b1 ();
  mod_updown_counter_if #(.WIDTH(4)) b2 ();

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    b0.en = 0; b0.up_dn = 1; b0.load = 0; b0.load_val = 0; b0.one_shot = 0;
    b1.en = 0; b1.up_dn = 1; b1.load = 0; b1.load_val = 0; b1.one_shot = 0;
    b2.en = 0; b2.up_dn = 1; b2.load = 0; b2.load_val = 0; b2.one_shot = 0;
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    b0.en = 1; b0.up_dn = 1; b0.load = 0; b0.load_val = 0; b0.one_shot = 0;
    rst = 1;
    cyc();
    cyc();
    total++; if (b0.count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", b0.count); end
    total++; if (b0.upper !== 1'b0) begin bad++; $display("FAIL rst_upper got=%0b want=0", b0.upper); end
    total++; if (b0.tc !== 1'b0)    begin bad++; $display("FAIL rst_tc got=%0b want=0", b0.tc); end
    total++; if (b0.done !== 1'b0)  begin bad++; $display("FAIL rst_done got=%0b want=0", b0.done); end
  endtask

  task automatic test_count_up();
    logic [3:0] exp;
    reset_all();
    b0.en = 1; b0.up_dn = 1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      exp = 4'(i % 16);
      total++; if (b0.count !== exp) begin bad++; $display("FAIL up_count i=%0d got=%0d want=%0d", i, b0.count, exp); end
      total++; if (b0.upper !== (exp >= 4'd8)) begin bad++; $display("FAIL up_upper i=%0d got=%0b want=%0b", i, b0.upper, exp >= 4'd8); end
      total++; if (b0.tc !== (i == 16)) begin bad++; $display("FAIL up_tc i=%0d got=%0b want=%0b", i, b0.tc, i == 16); end
    end
    b0.en = 0;
  endtask

  task automatic test_count_down_mod10();
    logic [3:0] exp;
    reset_all();
    b1.en = 1; b1.up_dn = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = 4'((10 - (i % 10)) % 10);
      total++; if (b1.count !== exp) begin bad++; $display("FAIL dn_count i=%0d got=%0d want=%0d", i, b1.count, exp); end
      total++; if (b1.upper !== (exp >= 4'd5)) begin bad++; $display("FAIL dn_upper i=%0d got=%0b want=%0b", i, b1.upper, exp >= 4'd5); end
      total++; if (b1.tc !== (exp == 4'd9)) begin bad++; $display("FAIL dn_tc i=%0d got=%0b want=%0b", i, b1.tc, exp == 4'd9); end
    end
    b1.en = 0;
  endtask

  task automatic test_prescale();
    logic       en_pat [14] = '{1,1,1,1,1,1,1,0,0,1,1,1,1,1};
    logic [3:0] exp_cnt[14] = '{0,0,1,1,1,2,2,2,2,2,3,3,3,4};
    reset_all();
    b2.up_dn = 1;
    for (int i = 0; i < 14; i++) begin
      b2.en = en_pat[i];
      cyc();
      total++; if (b2.count !== exp_cnt[i]) begin bad++; $display("FAIL ps_count clk=%0d got=%0d want=%0d", i + 1, b2.count, exp_cnt[i]); end
    end
    b2.en = 0;
  endtask

  task automatic test_one_shot();
    reset_all();
    b0.one_shot = 1; b0.load_val = 4'd13; b0.load = 1; b0.en = 0; b0.up_dn = 1;
    cyc();
    b0.load = 0;
    total++; if (b0.count !== 4'd13) begin bad++; $display("FAIL os_load got=%0d want=13", b0.count); end
    b0.en = 1;
    cyc();
    total++; if (b0.count !== 4'd14) begin bad++; $display("FAIL os_14 got=%0d want=14", b0.count); end
    cyc();
    total++; if (b0.count !== 4'd15) begin bad++; $display("FAIL os_15 got=%0d want=15", b0.count); end
    total++; if (b0.done !== 1'b0)   begin bad++; $display("FAIL os_done_early got=%0b want=0", b0.done); end
    cyc();
    total++; if (b0.count !== 4'd15) begin bad++; $display("FAIL os_hold got=%0d want=15", b0.count); end
    total++; if (b0.tc !== 1'b1)     begin bad++; $display("FAIL os_tc got=%0b want=1", b0.tc); end
    total++; if (b0.done !== 1'b1)   begin bad++; $display("FAIL os_done got=%0b want=1", b0.done); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (b0.count !== 4'd15) begin bad++; $display("FAIL os_frozen k=%0d got=%0d want=15", i, b0.count); end
      total++; if (b0.tc !== 1'b0)     begin bad++; $display("FAIL os_tc_single k=%0d got=%0b want=0", i, b0.tc); end
    end
    b0.one_shot = 0;
    cyc();
    cyc();
    total++; if (b0.count !== 4'd15) begin bad++; $display("FAIL os_halt_stays got=%0d want=15", b0.count); end
    total++; if (b0.done !== 1'b1)   begin bad++; $display("FAIL os_done_sticky got=%0b want=1", b0.done); end
    b0.load_val = 4'd2; b0.load = 1;
    cyc();
    b0.load = 0;
    total++; if (b0.count !== 4'd2) begin bad++; $display("FAIL os_reload got=%0d want=2", b0.count); end
    total++; if (b0.done !== 1'b0)  begin bad++; $display("FAIL os_done_clr got=%0b want=0", b0.done); end
    cyc();
    total++; if (b0.count !== 4'd3) begin bad++; $display("FAIL os_resume got=%0d want=3", b0.count); end
    b0.en = 0;
  endtask

  task automatic test_load_clamp();
    reset_all();
    b1.up_dn = 1; b1.en = 0; b1.load_val = 4'd12; b1.load = 1;
    cyc();
    total++; if (b1.count !== 4'd9) begin bad++; $display("FAIL clamp12 got=%0d want=9", b1.count); end
    total++; if (b1.upper !== 1'b1) begin bad++; $display("FAIL clamp_upper got=%0b want=1", b1.upper); end
    b1.load_val = 4'd15;
    cyc();
    total++; if (b1.count !== 4'd9) begin bad++; $display("FAIL clamp15 got=%0d want=9", b1.count); end
    b1.load_val = 4'd4; b1.en = 1;
    cyc();
    total++; if (b1.count !== 4'd4) begin bad++; $display("FAIL load_en_nostep got=%0d want=4", b1.count); end
    b1.load = 0;
    cyc();
    total++; if (b1.count !== 4'd5) begin bad++; $display("FAIL after_load_step got=%0d want=5", b1.count); end
    b1.en = 0;
  endtask

  task automatic test_async_reset();
    reset_all();
    b2.up_dn = 1; b2.one_shot = 1; b2.load_val = 4'd14; b2.load = 1;
    cyc();
    b2.load = 0; b2.en = 1;
    for (int i = 0; i < 6; i++) cyc();
    total++; if (b2.count !== 4'd15) begin bad++; $display("FAIL ar_pre_count got=%0d want=15", b2.count); end
    total++; if (b2.done !== 1'b1)   begin bad++; $display("FAIL ar_pre_done got=%0b want=1", b2.done); end
    total++; if (b2.tc !== 1'b1)     begin bad++; $display("FAIL ar_pre_tc got=%0b want=1", b2.tc); end
    #3 rst = 1;
    #1;
    total++; if (b2.count !== 4'd0) begin bad++; $display("FAIL ar_count got=%0d want=0", b2.count); end
    total++; if (b2.done !== 1'b0)  begin bad++; $display("FAIL ar_done got=%0b want=0", b2.done); end
    total++; if (b2.tc !== 1'b0)    begin bad++; $display("FAIL ar_tc got=%0b want=0", b2.tc); end
    cyc();
    rst = 0;
    b2.one_shot = 0; b2.load_val = 4'd6; b2.load = 1;
    cyc();
    b2.load = 0;
    cyc();
    total++; if (b2.count !== 4'd6) begin bad++; $display("FAIL ar_mid_pre got=%0d want=6", b2.count); end
    #3 rst = 1;
    #1;
    total++; if (b2.count !== 4'd0) begin bad++; $display("FAIL ar_mid_count got=%0d want=0", b2.count); end
    cyc();
    rst = 0;
    cyc();
    cyc();
    total++; if (b2.count !== 4'd0) begin bad++; $display("FAIL ar_restart_wait got=%0d want=0", b2.count); end
    cyc();
    total++; if (b2.count !== 4'd1) begin bad++; $display("FAIL ar_restart_step got=%0d want=1", b2.count); end
    b2.en = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    b1.en = 0; b1.up_dn = 1; b1.load = 0; b1.load_val = 0; b1.one_shot = 0;
    b2.en = 0; b2.up_dn = 1; b2.load = 0; b2.load_val = 0; b2.one_shot = 0;
    test_reset();
    test_count_up();
    test_count_down_mod10();
    test_prescale();
    test_one_shot();
    test_load_clamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
